spi_slave_regbank: RTL and testbench

- Parametrised successor SPI slave register bank for the multi-channel RF control path: NUM_CHANNELS packed channel words (spare/RxTx/phase/gain), one aux word, control, status and ID.
- Adds burst auto-increment, shadow/active double buffering with a commit command, a write lock, and a frame-abort counter.
- Sits between the board SPI master and the channel drivers.

---
 rtl/spi_slave_regbank.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave_regbank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regbank.sv
// rtl/spi_slave_regbank.sv - SPI slave register bank with shadow/active channel words
module spi_slave_regbank #(
    parameter int                    NUM_CHANNELS = 8,
    parameter int                    ADDR_WIDTH   = 7,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    SPARE_W      = 4,
    parameter int                    PHASE_W      = 6,
    parameter int                    GAIN_W       = 5,
    parameter logic [DATA_WIDTH-1:0] PRODUCT_ID   = 16'h0500,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_CH   = 16'h6AAA,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_AUX  = 16'h6AAA
) (
    input  logic                            SlaveClock,
    input  logic                            SlaveChipSelect_ResetButton,
    input  logic                            ResetButton_n,
    input  logic                            SlaveDataIn,
    output logic                            SlaveDataOut,
    output logic [NUM_CHANNELS*SPARE_W-1:0] Channel_Spare,
    output logic [NUM_CHANNELS-1:0]         Channel_RxTx,
    output logic [NUM_CHANNELS*PHASE_W-1:0] Channel_Phase,
    output logic [NUM_CHANNELS*GAIN_W-1:0]  Channel_Gain,
    output logic [DATA_WIDTH-1:0]           AuxChannel,
    output logic                            CommitToggle
);

    localparam int CW = $clog2(DATA_WIDTH > ADDR_WIDTH ? DATA_WIDTH : ADDR_WIDTH);

    localparam logic [ADDR_WIDTH-1:0] A_AUX      = ADDR_WIDTH'('h40);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'('h7B);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'('h7C);
    localparam logic [ADDR_WIDTH-1:0] A_ID       = ADDR_WIDTH'('h7D);
    localparam logic [ADDR_WIDTH-1:0] A_COMMIT   = ADDR_WIDTH'('h7E);
    localparam logic [ADDR_WIDTH-1:0] A_DEFAULTS = ADDR_WIDTH'('h7F);
    localparam logic [DATA_WIDTH-1:0] DEF_KEY    = DATA_WIDTH'('hA5A5);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           bitcnt_q;
    logic                    rw_q;
    logic [ADDR_WIDTH-2:0]   addr_sh_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-2:0]   rx_sh_q;
    logic [DATA_WIDTH-1:0]   tx_buf_q;
    logic                    miso_q;

    logic [DATA_WIDTH-1:0]   ch_shadow_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   ch_active_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   aux_shadow_q, aux_active_q;
    logic [1:0]              ctrl_q;
    logic [7:0]              abort_q;
    logic                    pending_q, commit_tgl_q, word_active_q;

    logic                    frame_start, addr_done, word_done, wr_en;
    logic                    wlock, autoinc;
    logic [ADDR_WIDTH-1:0]   addr_full, next_addr, rd_addr;
    logic [DATA_WIDTH-1:0]   rx_word, rd_data;

    assign wlock     = ctrl_q[0];
    assign autoinc   = ctrl_q[1];
    assign addr_full = {addr_sh_q, SlaveDataIn};
    assign rx_word   = {rx_sh_q, SlaveDataIn};
    assign next_addr = autoinc ? addr_q + ADDR_WIDTH'(1) : addr_q;
    assign rd_addr   = (state_q == S_ADDR) ? addr_full : next_addr;
    assign wr_en     = word_done && rw_q;

    // State register; every CS/reset assertion returns to IDLE
    always_ff @(posedge SlaveClock or posedge SlaveChipSelect_ResetButton) begin
        if (SlaveChipSelect_ResetButton) state_q <= S_IDLE;
        else                             state_q <= state_d;
    end

    // Next state: one R/W bit, the address, then data words until CS rises
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_ADDR;
            S_ADDR:  if (bitcnt_q == CW'(ADDR_WIDTH - 1)) state_d = S_DATA;
            S_DATA:  state_d = S_DATA;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame event strobes
    always_comb begin
        frame_start = (state_q == S_IDLE);
        addr_done   = (state_q == S_ADDR) && (bitcnt_q == CW'(ADDR_WIDTH - 1));
        word_done   = (state_q == S_DATA) && (bitcnt_q == CW'(DATA_WIDTH - 1));
    end

    // Read mux shared by the address-phase load and the end-of-word prefetch
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) rd_data = ch_shadow_q[i];
        end
        case (rd_addr)
            A_AUX:    rd_data = aux_shadow_q;
            A_CTRL:   rd_data = DATA_WIDTH'({autoinc, wlock});
            A_STATUS: rd_data = DATA_WIDTH'({abort_q, 5'b0, pending_q, wlock, autoinc});
            A_ID:     rd_data = PRODUCT_ID;
            default:  ;
        endcase
    end

    // Shift/bit-count datapath on the sampling edge
    always_ff @(posedge SlaveClock or posedge SlaveChipSelect_ResetButton) begin
        if (SlaveChipSelect_ResetButton) begin
            bitcnt_q  <= '0;
            rw_q      <= 1'b0;
            addr_sh_q <= '0;
            addr_q    <= '0;
            rx_sh_q   <= '0;
            tx_buf_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rw_q     <= SlaveDataIn;
                    bitcnt_q <= '0;
                end
                S_ADDR: begin
                    addr_sh_q <= addr_full[ADDR_WIDTH-2:0];
                    if (addr_done) begin
                        addr_q   <= addr_full;
                        tx_buf_q <= rd_data;
                        bitcnt_q <= '0;
                    end else begin
                        bitcnt_q <= bitcnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    rx_sh_q <= rx_word[DATA_WIDTH-2:0];
                    if (word_done) begin
                        addr_q   <= next_addr;
                        tx_buf_q <= rd_data;
                        bitcnt_q <= '0;
                    end else begin
                        tx_buf_q <= {tx_buf_q[DATA_WIDTH-2:0], 1'b0};
                        bitcnt_q <= bitcnt_q + CW'(1);
                    end
                end
                default: bitcnt_q <= '0;
            endcase
        end
    end

    // MISO launched on the falling edge, only during read data phases
    always_ff @(negedge SlaveClock or posedge SlaveChipSelect_ResetButton) begin
        if (SlaveChipSelect_ResetButton) miso_q <= 1'b0;
        else miso_q <= (state_q == S_DATA && !rw_q) ? tx_buf_q[DATA_WIDTH-1] : 1'b0;
    end

    // Register bank; contents survive a CS-only reset and clear when the button is held
    always_ff @(posedge SlaveClock or posedge SlaveChipSelect_ResetButton) begin
        if (SlaveChipSelect_ResetButton) begin
            if (!ResetButton_n) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    ch_shadow_q[i] <= '0;
                    ch_active_q[i] <= '0;
                end
                aux_shadow_q  <= '0;
                aux_active_q  <= '0;
                ctrl_q        <= '0;
                abort_q       <= '0;
                pending_q     <= 1'b0;
                commit_tgl_q  <= 1'b0;
                word_active_q <= 1'b0;
            end
        end else begin
            // A word left open by the previous frame is counted as an abort
            if (frame_start && word_active_q) begin
                if (abort_q != 8'hFF) abort_q <= abort_q + 8'd1;
                word_active_q <= 1'b0;
            end
            if (addr_done) word_active_q <= 1'b1;
            if (word_done) word_active_q <= 1'b0;
            if (wr_en) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (addr_q == ADDR_WIDTH'(i) && !wlock) begin
                        ch_shadow_q[i] <= rx_word;
                        pending_q      <= 1'b1;
                    end
                end
                if (addr_q == A_AUX && !wlock) begin
                    aux_shadow_q <= rx_word;
                    pending_q    <= 1'b1;
                end
                if (addr_q == A_CTRL) ctrl_q <= rx_word[1:0];
                if (addr_q == A_COMMIT && !wlock) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) ch_active_q[i] <= ch_shadow_q[i];
                    aux_active_q <= aux_shadow_q;
                    commit_tgl_q <= ~commit_tgl_q;
                    pending_q    <= 1'b0;
                end
                if (addr_q == A_DEFAULTS && !wlock && rx_word == DEF_KEY) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) ch_shadow_q[i] <= DEFAULT_CH;
                    aux_shadow_q <= DEFAULT_AUX;
                    pending_q    <= 1'b1;
                end
            end
        end
    end

    // Unpack active channel words into per-field output buses
    always_comb begin
        Channel_Spare = '0;
        Channel_RxTx  = '0;
        Channel_Phase = '0;
        Channel_Gain  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            Channel_Gain[i*GAIN_W +: GAIN_W]    = ch_active_q[i][GAIN_W-1:0];
            Channel_Phase[i*PHASE_W +: PHASE_W] = ch_active_q[i][GAIN_W +: PHASE_W];
            Channel_RxTx[i]                     = ch_active_q[i][GAIN_W+PHASE_W];
            Channel_Spare[i*SPARE_W +: SPARE_W] = ch_active_q[i][GAIN_W+PHASE_W+1 +: SPARE_W];
        end
    end

    assign AuxChannel   = aux_active_q;
    assign CommitToggle = commit_tgl_q;
    assign SlaveDataOut = miso_q;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// tb/tb_spi_slave_regbank.sv - directed vector bench for spi_slave_regbank
module tb_spi_slave_regbank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rb_n = 1'b1;
    logic        din = 1'b0;
    logic        miso;
    logic [31:0] spare;
    logic [7:0]  rxtx;
    logic [47:0] phase;
    logic [39:0] gain;
    logic [15:0] aux;
    logic        tgl;

    int vec_count = 0;
    int miscompares = 0;

    logic [15:0] wr_words [4];
    logic [15:0] rd_words [4];

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [15];

    logic [31:0] def_spare = {8{4'h6}};
    logic [47:0] def_phase = {8{6'b010101}};
    logic [39:0] def_gain  = {8{5'b01010}};

    spi_slave_regbank dut (
        .SlaveClock                  (clk),
        .SlaveChipSelect_ResetButton (rst),
        .ResetButton_n               (rb_n),
        .SlaveDataIn                 (din),
        .SlaveDataOut                (miso),
        .Channel_Spare               (spare),
        .Channel_RxTx                (rxtx),
        .Channel_Phase               (phase),
        .Channel_Gain                (gain),
        .AuxChannel                  (aux),
        .CommitToggle                (tgl)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares + 1);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One CS-low frame; nbits data bits are clocked (less than nwords*16 aborts mid-word)
    task automatic spi_xfer(input logic rw, input logic [6:0] addr, input int nbits);
        logic [7:0] hdr;
        hdr = {rw, addr};
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            din = hdr[i];
            @(negedge clk); #1;
        end
        for (int b = 0; b < nbits; b++) begin
            rd_words[b/16][15 - (b%16)] = miso;
            din = rw ? wr_words[b/16][15 - (b%16)] : 1'b0;
            @(negedge clk); #1;
        end
        rst = 1'b1;
        din = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr1(input logic [6:0] addr, input logic [15:0] data);
        wr_words[0] = data;
        spi_xfer(1'b1, addr, 16);
    endtask

    task automatic rd1(input string tag, input logic [6:0] addr, input logic [15:0] exp);
        spi_xfer(1'b0, addr, 16);
        check(tag, {48'h0, rd_words[0]}, {48'h0, exp});
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        rb_n = 1'b0;
        repeat (3) @(negedge clk);
        rb_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 7'h7C, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 7'h7D, 16'h0000, 16'h0500};
        vecs[2]  = '{1'b0, 7'h7E, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 7'h50, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b1, 7'h02, 16'h1234, 16'h0000};
        vecs[5]  = '{1'b0, 7'h02, 16'h0000, 16'h1234};
        vecs[6]  = '{1'b0, 7'h03, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b1, 7'h40, 16'hBEEF, 16'h0000};
        vecs[8]  = '{1'b0, 7'h40, 16'h0000, 16'hBEEF};
        vecs[9]  = '{1'b1, 7'h7B, 16'hFFFF, 16'h0000};
        vecs[10] = '{1'b0, 7'h7B, 16'h0000, 16'h0003};
        vecs[11] = '{1'b1, 7'h7B, 16'h0000, 16'h0000};
        vecs[12] = '{1'b0, 7'h7C, 16'h0000, 16'h0004};
        vecs[13] = '{1'b1, 7'h7D, 16'h1111, 16'h0000};
        vecs[14] = '{1'b0, 7'h7D, 16'h0000, 16'h0500};

        hard_reset();
        check("rst_spare", 64'(spare), 64'h0);
        check("rst_phase_gain", {phase[23:0], gain}, 64'h0);
        check("rst_rxtx_aux_tgl_miso", {39'h0, rxtx, aux, tgl}, {39'h0, 8'h0, 16'h0, 1'b0});
        check("rst_miso", 64'(miso), 64'h0);

        for (int v = 0; v < 15; v++) begin
            wr_words[0] = vecs[v].wdata;
            spi_xfer(vecs[v].rw, vecs[v].addr, 16);
            check($sformatf("vec%0d", v), {48'h0, rd_words[0]}, {48'h0, vecs[v].exp_rd});
        end

        // Shadow writes must not reach outputs until COMMIT
        check("precommit_spare", 64'(spare), 64'h0);
        check("precommit_aux", 64'(aux), 64'h0);
        wr1(7'h7E, 16'h0000);
        check("c1_spare", 64'(spare), 64'h0000_0100);
        check("c1_rxtx", 64'(rxtx), 64'h0);
        check("c1_phase", 64'(phase), 64'h11000);
        check("c1_gain", 64'(gain), 64'h5000);
        check("c1_aux", 64'(aux), 64'hBEEF);
        check("c1_tgl", 64'(tgl), 64'h1);
        rd1("c1_status", 7'h7C, 16'h0000);

        // Auto-increment burst write, then burst read wrapping 0x7F -> 0x00
        wr1(7'h7B, 16'h0002);
        wr_words[0] = 16'h1111;
        wr_words[1] = 16'h2222;
        wr_words[2] = 16'h3333;
        spi_xfer(1'b1, 7'h00, 48);
        spi_xfer(1'b0, 7'h7F, 32);
        check("wrap_rd0", 64'(rd_words[0]), 64'h0000);
        check("wrap_rd1", 64'(rd_words[1]), 64'h1111);
        rd1("burst_ch1", 7'h01, 16'h2222);
        rd1("burst_ch2", 7'h02, 16'h3333);
        rd1("burst_status", 7'h7C, 16'h0005);
        wr1(7'h7E, 16'h0000);
        check("c2_spare", 64'(spare), 64'h0000_0321);
        check("c2_gain", 64'(gain), 64'h4C51);
        check("c2_tgl", 64'(tgl), 64'h0);

        // Write lock blocks channel and COMMIT writes
        wr1(7'h7B, 16'h0001);
        rd1("lock_ctrl", 7'h7B, 16'h0001);
        wr1(7'h00, 16'hFFFF);
        wr1(7'h7E, 16'h0000);
        check("lock_spare", 64'(spare), 64'h0000_0321);
        check("lock_gain", 64'(gain), 64'h4C51);
        check("lock_tgl", 64'(tgl), 64'h0);
        rd1("lock_ch0", 7'h00, 16'h1111);
        rd1("lock_status", 7'h7C, 16'h0002);

        // CS raised after 5 data bits: counted on the next frame
        wr1(7'h7B, 16'h0000);
        wr_words[0] = 16'hFFFF;
        spi_xfer(1'b1, 7'h01, 5);
        rd1("abort_status", 7'h7C, 16'h0100);
        rd1("abort_ch1", 7'h01, 16'h2222);

        // DEFAULTS with the key, then COMMIT
        wr1(7'h7F, 16'hA5A5);
        rd1("def_status", 7'h7C, 16'h0104);
        rd1("def_ch3", 7'h03, 16'h6AAA);
        wr1(7'h7E, 16'h0000);
        check("def_spare", 64'(spare), 64'(def_spare));
        check("def_rxtx", 64'(rxtx), 64'hFF);
        check("def_phase", 64'(phase), 64'(def_phase));
        check("def_gain", 64'(gain), 64'(def_gain));
        check("def_aux", 64'(aux), 64'h6AAA);
        check("def_tgl", 64'(tgl), 64'h1);

        // DEFAULTS with a wrong key is ignored
        wr1(7'h05, 16'h0000);
        wr1(7'h7F, 16'h1234);
        rd1("badkey_ch5", 7'h05, 16'h0000);
        rd1("badkey_ch6", 7'h06, 16'h6AAA);

        // Button reset clears everything, including the abort counter
        hard_reset();
        check("rst2_spare", 64'(spare), 64'h0);
        check("rst2_aux_tgl", {47'h0, aux, tgl}, 64'h0);
        rd1("rst2_status", 7'h7C, 16'h0000);
        rd1("rst2_ch6", 7'h06, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
